// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the reconstructing divider checker.
// The state enum is also used by the divider test infrastructure.
package div_pkg;

    localparam int DIVIDEND_DEF = 16;
    localparam int DIVISOR_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_recon_step.sv
// One shift-add step: add quotient<<idx to the accumulator when divisor bit idx is set.
module div_recon_step #(
    parameter int DIVIDEND = 16,
    parameter int DIVISOR  = 8,
    parameter int IDX_W    = 4
) (
    input  logic [DIVIDEND+DIVISOR-1:0] acc,
    input  logic [DIVIDEND-1:0]         quo,
    input  logic [DIVISOR-1:0]          div,
    input  logic [IDX_W-1:0]            idx,
    output logic [DIVIDEND+DIVISOR-1:0] acc_nxt
);

    localparam int ACC_W = DIVIDEND + DIVISOR;

    logic             bit_on;
    logic [ACC_W-1:0] addend;

    always_comb begin
        bit_on  = |(div & (DIVISOR'(1) << idx));
        addend  = ACC_W'(quo) << idx;
        acc_nxt = bit_on ? (acc + addend) : acc;
    end

endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a serial shift-add,
// one divisor bit per CALC cycle, behind a valid/ready handshake on both sides.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready high
//  CALC  | one shift-add step per cycle, DIVISOR cycles
//  DONE  | result held on outputs until out_ready
module div_reconstruct
    import div_pkg::*;
#(
    parameter int DIVIDEND = DIVIDEND_DEF,
    parameter int DIVISOR  = DIVISOR_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIVIDEND-1:0]          quotient,
    input  logic [DIVISOR-1:0]           divisor,
    input  logic [DIVISOR-1:0]           remainder,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIVIDEND+DIVISOR-1:0]  dividend,
    output logic                         overflow,
    output logic                         rem_err
);

    localparam int ACC_W = DIVIDEND + DIVISOR;
    localparam int CNT_W = $clog2(DIVISOR + 1);

    div_state_e          state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    idx;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [DIVIDEND-1:0] q_reg;
    logic [DIVISOR-1:0]  d_reg;
    logic                rem_err_q;

    // Counter runs DIVISOR..1, so the LSB-first step index is DIVISOR-cnt.
    assign idx = CNT_W'(DIVISOR) - cnt;

    div_recon_step #(
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .IDX_W    (CNT_W)
    ) u_step (
        .acc     (acc),
        .quo     (q_reg),
        .div     (d_reg),
        .idx     (idx),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            rem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg     <= quotient;
                        d_reg     <= divisor;
                        acc       <= ACC_W'(remainder);
                        cnt       <= CNT_W'(DIVISOR);
                        rem_err_q <= (remainder >= divisor);
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)              state_nxt = CALC;
            CALC: if (cnt == CNT_W'(1))      state_nxt = DONE;
            DONE: if (out_ready)             state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, not just after the reset edge.
    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = rst_n && (state == DONE);
        dividend  = rst_n ? acc : '0;
        overflow  = rst_n && (|acc[ACC_W-1:DIVIDEND]);
        rem_err   = rst_n && rem_err_q;
    end

endmodule

// File: doc/div_reconstruct.md
DIV_RECONSTRUCT -- requirements
Module: div_reconstruct

Interface
REQ-001 Parameter DIVIDEND, default 16, SHALL set the width of the quotient operand.
REQ-002 Parameter DIVISOR, default 8, SHALL set the width of the divisor and remainder operands.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-005 Port in_valid, input, 1 bit, SHALL mark the operand inputs as valid.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate the block can accept operands.
REQ-007 Port quotient, input, DIVIDEND bits, SHALL be the unsigned quotient operand.
REQ-008 Port divisor, input, DIVISOR bits, SHALL be the unsigned divisor operand.
REQ-009 Port remainder, input, DIVISOR bits, SHALL be the unsigned remainder operand.
REQ-010 Port out_valid, output, 1 bit, SHALL mark the result outputs as valid.
REQ-011 Port out_ready, input, 1 bit, SHALL indicate the consumer accepts the result.
REQ-012 Port dividend, output, DIVIDEND+DIVISOR bits, SHALL carry the reconstructed dividend, quotient*divisor+remainder.
REQ-013 Port overflow, output, 1 bit, SHALL be 1 when dividend[DIVIDEND+DIVISOR-1:DIVIDEND] is nonzero.
REQ-014 Port rem_err, output, 1 bit, SHALL be 1 when remainder >= divisor, which includes divisor==0.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur on an edge where in_valid&&in_ready; all operands are registered at that edge.
REQ-018 On a transfer, the accumulator SHALL be loaded with zero-extended remainder and rem_err SHALL be computed from the registered operands.
REQ-019 On a transfer, the bit counter SHALL be loaded with DIVISOR and the FSM SHALL go IDLE->CALC.
REQ-020 Each CALC cycle SHALL do one shift-add step.
REQ-021 In that step, if the divisor bit (LSB first) is 1, quotient shifted left by the step index SHALL be added to the accumulator.
REQ-022 The counter SHALL decrement once per CALC cycle; CALC SHALL last exactly DIVISOR cycles, then go CALC->DONE.
REQ-023 out_valid SHALL be 1 only in DONE, first at edge T+DIVISOR+1, where T is the transfer edge.
REQ-024 In DONE, dividend, overflow and rem_err SHALL be stable while out_valid&&!out_ready, for unbounded backpressure.
REQ-025 On an edge where out_valid&&out_ready, the FSM SHALL go DONE->IDLE; the next transfer is possible one cycle later.
REQ-026 The accumulator SHALL be DIVIDEND+DIVISOR bits; the maximum result (2^DIVIDEND-1)(2^DIVISOR-1)+2^DIVISOR-1 fits without truncation.
REQ-027 divisor==0 SHALL yield dividend=remainder and rem_err=1, with no other special-casing.
REQ-028 rem_err SHALL be informational only; the result is still computed.
REQ-029 in_valid, in_ready and operand changes SHALL be ignored in CALC and DONE.

Reset
REQ-030 When rst_n==0 at a rising edge, the FSM SHALL go to IDLE from any state, including mid-CALC and DONE; a partial result is discarded.
REQ-031 During reset, in_ready, out_valid, overflow and rem_err SHALL be 0, and dividend SHALL be 0.
REQ-032 The first transfer after reset SHALL be possible on the first edge with rst_n==1.

Structure
REQ-033 Package div_pkg SHALL hold the default DIVIDEND/DIVISOR constants and the FSM state enum type.
REQ-034 The state enum SHALL be shared with the divider test infrastructure.
REQ-035 Sub-module div_recon_step SHALL hold the combinational shift-add step (accumulator, quotient, bit index -> next accumulator).
REQ-036 No other hierarchy SHALL be used.

Verification
REQ-037 quotient=100, divisor=7, remainder=3 -> dividend=703, overflow=0, rem_err=0, out_valid at T+9.
REQ-038 quotient=1234, divisor=0, remainder=5 -> dividend=5, rem_err=1, overflow=0.
REQ-039 quotient=65535, divisor=255, remainder=255 -> dividend=0xFF0000, overflow=1, rem_err=1.
REQ-040 quotient=300, divisor=10, remainder=9, with out_ready=0 for 5 cycles after out_valid -> outputs stay 3009 and out_valid stays 1; in_ready=1 the cycle after the handshake.
REQ-041 rst_n=0 at CALC cycle 4, then a new transfer quotient=2, divisor=3, remainder=1 -> dividend=7, with no residue from the aborted operation.
REQ-042 Exhaustive loop over all divisor/quotient pairs with remainder<divisor, fed from divider outputs -> dividend equals the original dividend and overflow=0 for every pair.
